clock_prog_ctrl: RTL and testbench
==================================

Name: clock_prog_ctrl

Overview:
- Sequencer and arbiter for the CLOCK generator. Shares one CLOCK instance between two requesters.
- Per request it loads counter, ref_counter and init into CLOCK, holds CLOCK in reset, waits for a stable lock on CLOCK status, and reports done or fail.
- While locked it monitors for loss of lock and automatically re-runs the sequence with the last configuration.
- Sits beside CLOCK in ref_clk domain; CLOCK's resetn, ref_counter, init and counter inputs are driven solely by this block.

Parameters:
RST_CYCLES, 16, cycles clk_resetn is held low per programming attempt (>=1)
STABLE_CYCLES, 8, consecutive cycles clk_status must equal LOCK_STATUS to declare lock (>=1)
LOCK_TIMEOUT, 4096, max cycles in WAIT before an attempt fails (>STABLE_CYCLES)
MAX_RETRY, 2, extra attempts after the first timeout before fail
LOSS_CYCLES, 4, consecutive non-lock cycles in LOCKED that trigger relock (>=1)
LOCK_STATUS, 3'b100, clk_status code meaning locked

Ports:
ref_clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  2  request per requester; held high until ack or fail pulse
cfg0_counter  in  32  requester 0 target counter
cfg0_ref_counter  in  32  requester 0 reference counter
cfg0_init  in  9  requester 0 init value
cfg1_counter  in  32  requester 1 target counter
cfg1_ref_counter  in  32  requester 1 reference counter
cfg1_init  in  9  requester 1 init value
ack  out  2  one-cycle pulse: owner's configuration locked
fail  out  2  one-cycle pulse: owner's configuration failed all attempts
owner  out  1  index of requester whose configuration is loaded
busy  out  1  high in LOAD and WAIT
locked  out  1  high in LOCKED only
relock_cnt  out  8  saturating count of automatic relocks
clk_resetn  out  1  to CLOCK resetn (active-low)
clk_counter  out  32  to CLOCK counter
clk_ref_counter  out  32  to CLOCK ref_counter
clk_init  out  9  to CLOCK init
clk_status  in  3  from CLOCK status

Behaviour:
- Reset: state IDLE; clk_resetn=0; clk_counter, clk_ref_counter, clk_init = 0; ack, fail = 0; owner=0; busy=0; locked=0; relock_cnt=0; round-robin pointer last=1, so requester 0 wins the first tie. Reset mid-sequence aborts with no ack or fail pulse.
- States: IDLE, LOAD, WAIT, LOCKED. All outputs are registered.
- Arbitration (IDLE, or LOCKED with any req bit high): one requester high -> grant it. Both high -> grant ~last.
- On the grant edge: latch that requester's cfg into the clk_* outputs; owner := index; last := index; retry count := 0. Next state LOAD.
- The requester that is currently owner and locked must drop req after ack. A req still high in LOCKED is a new reprogram request.
- LOAD: clk_resetn=0 for exactly RST_CYCLES cycles, then WAIT with clk_resetn=1.
- WAIT:
  - Cycle timer starts at 0 and increments each cycle.
  - Stable counter increments while clk_status==LOCK_STATUS; any mismatch clears it.
  - Stable counter reaches STABLE_CYCLES -> LOCKED, with ack[owner] pulsed on the first LOCKED cycle.
  - Timer reaches LOCK_TIMEOUT first:
    - retries < MAX_RETRY -> retries++, back to LOAD.
    - otherwise -> IDLE, with fail[owner] pulsed on the first IDLE cycle; clk_resetn stays 0; clk_* config holds its last value.
  - If lock completion and timeout fall on the same cycle, lock wins.
- LOCKED:
  - Loss counter increments while clk_status!=LOCK_STATUS; clears on match.
  - Loss counter reaches LOSS_CYCLES -> relock_cnt++ (saturates at 255), retries := 0, LOAD with the same cfg. A relock success produces no ack. A relock that exhausts retries pulses fail[owner].
  - A pending req has priority over loss detection in the same cycle (reprogram; relock_cnt unchanged).
- req is ignored while busy; it is arbitrated once the block returns to IDLE or LOCKED. Dropping req mid-sequence does not abort; the pulse is still issued.
- ack and fail are never both high; each pulse lasts one cycle.

Test Plan:
- Basic lock: req=01 with cfg0 = (2000, 10, 20); model holds status=LOCK_STATUS from the cycle after clk_resetn rises -> clk_resetn low 16 cycles; ack[0] pulses 8 cycles after release; locked=1; clk_counter=2000, clk_ref_counter=10, clk_init=20.
- Arbitration: req=11 from IDLE -> requester 0 served first, then requester 1 (cfg1 = 4000, 20, 40) is granted from LOCKED after req[0] drops; owner=1; ack[1] pulses; clk_counter=4000.
- Timeout/retry: status never locks -> three LOAD/WAIT attempts, each WAIT lasting 4096 cycles; fail[0] pulses once; clk_resetn=0; locked=0.
- Retry success: status locks only during the second attempt -> single ack, with no fail pulse.
- Loss of lock: in LOCKED, status deasserted 3 cycles -> stays locked; deasserted 4 cycles -> relock_cnt=1, LOAD re-entered with the same cfg, no ack on relock success.
- Reset mid-WAIT: assert reset -> next cycle all outputs at their reset values; no ack or fail pulse.

Source files
------------

// File: rtl/clock_prog_ctrl.sv
// rtl/clock_prog_ctrl.sv - two-requester sequencer and arbiter for the CLOCK generator
//
// Ports:
//   ref_clk, reset          clock and synchronous active-high reset
//   req[1:0]                per-requester programming request
//   cfg{0,1}_counter        requester target counter
//   cfg{0,1}_ref_counter    requester reference counter
//   cfg{0,1}_init           requester init value
//   ack[1:0], fail[1:0]     one-cycle result pulses for the owner
//   owner                   requester whose configuration is loaded
//   busy, locked            LOAD/WAIT and LOCKED indicators
//   relock_cnt              saturating count of automatic relocks
//   clk_resetn, clk_counter, clk_ref_counter, clk_init   drive CLOCK
//   clk_status              CLOCK status input
module clock_prog_ctrl #(
    parameter int         RST_CYCLES    = 16,
    parameter int         STABLE_CYCLES = 8,
    parameter int         LOCK_TIMEOUT  = 4096,
    parameter int         MAX_RETRY     = 2,
    parameter int         LOSS_CYCLES   = 4,
    parameter logic [2:0] LOCK_STATUS   = 3'b100
) (
    input  logic        ref_clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] cfg0_counter,
    input  logic [31:0] cfg0_ref_counter,
    input  logic [8:0]  cfg0_init,
    input  logic [31:0] cfg1_counter,
    input  logic [31:0] cfg1_ref_counter,
    input  logic [8:0]  cfg1_init,
    output logic [1:0]  ack,
    output logic [1:0]  fail,
    output logic        owner,
    output logic        busy,
    output logic        locked,
    output logic [7:0]  relock_cnt,
    output logic        clk_resetn,
    output logic [31:0] clk_counter,
    output logic [31:0] clk_ref_counter,
    output logic [8:0]  clk_init,
    input  logic [2:0]  clk_status
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int LW = $clog2(LOSS_CYCLES + 1);
    localparam int YW = $clog2(MAX_RETRY + 2);

    logic [1:0]    state;
    logic          last;
    logic          relock;      // current sequence is an automatic relock: success is silent
    logic [RW-1:0] rst_cnt;
    logic [TW-1:0] timer;
    logic [SW-1:0] stable_cnt;
    logic [LW-1:0] loss_cnt;
    logic [YW-1:0] retry_cnt;

    logic          status_ok;
    logic          grant;
    logic          grant_idx;
    logic [TW-1:0] timer_nxt;
    logic [SW-1:0] stable_nxt;
    logic [LW-1:0] loss_nxt;
    logic [1:0]    owner_mask;

    always_comb begin
        status_ok  = (clk_status == LOCK_STATUS);
        grant      = ((state == ST_IDLE) || (state == ST_LOCKED)) && (req != 2'b00);
        grant_idx  = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last;
            default: grant_idx = 1'b0;
        endcase
        timer_nxt  = timer + TW'(1);
        stable_nxt = status_ok ? stable_cnt + SW'(1) : '0;
        loss_nxt   = status_ok ? '0 : loss_cnt + LW'(1);
        owner_mask = owner ? 2'b10 : 2'b01;
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            last            <= 1'b1;
            relock          <= 1'b0;
            rst_cnt         <= '0;
            timer           <= '0;
            stable_cnt      <= '0;
            loss_cnt        <= '0;
            retry_cnt       <= '0;
            ack             <= 2'b00;
            fail            <= 2'b00;
            owner           <= 1'b0;
            busy            <= 1'b0;
            locked          <= 1'b0;
            relock_cnt      <= 8'd0;
            clk_resetn      <= 1'b0;
            clk_counter     <= 32'd0;
            clk_ref_counter <= 32'd0;
            clk_init        <= 9'd0;
        end else begin
            ack  <= 2'b00;
            fail <= 2'b00;
            // A pending request outranks loss detection while locked.
            if (grant) begin
                state           <= ST_LOAD;
                owner           <= grant_idx;
                last            <= grant_idx;
                retry_cnt       <= '0;
                relock          <= 1'b0;
                rst_cnt         <= '0;
                busy            <= 1'b1;
                locked          <= 1'b0;
                clk_resetn      <= 1'b0;
                clk_counter     <= grant_idx ? cfg1_counter     : cfg0_counter;
                clk_ref_counter <= grant_idx ? cfg1_ref_counter : cfg0_ref_counter;
                clk_init        <= grant_idx ? cfg1_init        : cfg0_init;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                            state      <= ST_WAIT;
                            clk_resetn <= 1'b1;
                            timer      <= '0;
                            stable_cnt <= '0;
                        end else begin
                            rst_cnt <= rst_cnt + RW'(1);
                        end
                    end
                    ST_WAIT: begin
                        // Lock completion is tested first so it wins a tie with the timeout.
                        if (stable_nxt == SW'(STABLE_CYCLES)) begin
                            state    <= ST_LOCKED;
                            busy     <= 1'b0;
                            locked   <= 1'b1;
                            loss_cnt <= '0;
                            ack      <= relock ? 2'b00 : owner_mask;
                        end else if (timer_nxt == TW'(LOCK_TIMEOUT)) begin
                            clk_resetn <= 1'b0;
                            if (retry_cnt < YW'(MAX_RETRY)) begin
                                state     <= ST_LOAD;
                                retry_cnt <= retry_cnt + YW'(1);
                                rst_cnt   <= '0;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                fail  <= owner_mask;
                            end
                        end else begin
                            timer      <= timer_nxt;
                            stable_cnt <= stable_nxt;
                        end
                    end
                    ST_LOCKED: begin
                        if (loss_nxt == LW'(LOSS_CYCLES)) begin
                            state      <= ST_LOAD;
                            relock     <= 1'b1;
                            retry_cnt  <= '0;
                            rst_cnt    <= '0;
                            busy       <= 1'b1;
                            locked     <= 1'b0;
                            clk_resetn <= 1'b0;
                            if (relock_cnt != 8'hFF) begin
                                relock_cnt <= relock_cnt + 8'd1;
                            end
                        end else begin
                            loss_cnt <= loss_nxt;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_prog_ctrl.sv
// tb/tb_clock_prog_ctrl.sv - directed self-checking bench for clock_prog_ctrl
module tb_clock_prog_ctrl;

    localparam logic [2:0] LOCK = 3'b100;

    logic        ref_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [1:0]  req     = 2'b00;
    logic [31:0] cfg0_counter     = 32'd2000;
    logic [31:0] cfg0_ref_counter = 32'd10;
    logic [8:0]  cfg0_init        = 9'd20;
    logic [31:0] cfg1_counter     = 32'd4000;
    logic [31:0] cfg1_ref_counter = 32'd20;
    logic [8:0]  cfg1_init        = 9'd40;
    logic [1:0]  ack, fail;
    logic        owner, busy, locked, clk_resetn;
    logic [7:0]  relock_cnt;
    logic [31:0] clk_counter, clk_ref_counter;
    logic [8:0]  clk_init;
    logic [2:0]  clk_status;

    int errors = 0;
    int checks = 0;

    // CLOCK model: lock_mode 0 never locks, 1 locks whenever released,
    // 2 locks only from the second release of the current test onward.
    int lock_mode  = 1;
    bit force_loss = 1'b0;
    int rise_base  = 0;

    int n_load = 0, n_wait = 0, n_rise = 0;
    int n_ack0 = 0, n_ack1 = 0, n_fail0 = 0, n_fail1 = 0, n_both = 0;
    logic prev_rn = 1'b0;

    logic [1:0] seen_ack, seen_fail;
    logic       seen_owner;

    always #5 ref_clk = ~ref_clk;

    assign clk_status = (clk_resetn && !force_loss &&
                         (lock_mode == 1 || (lock_mode == 2 && (n_rise - rise_base) >= 2))) ? LOCK : 3'b001;

    clock_prog_ctrl dut (
        .ref_clk(ref_clk), .reset(reset), .req(req),
        .cfg0_counter(cfg0_counter), .cfg0_ref_counter(cfg0_ref_counter), .cfg0_init(cfg0_init),
        .cfg1_counter(cfg1_counter), .cfg1_ref_counter(cfg1_ref_counter), .cfg1_init(cfg1_init),
        .ack(ack), .fail(fail), .owner(owner), .busy(busy), .locked(locked),
        .relock_cnt(relock_cnt), .clk_resetn(clk_resetn), .clk_counter(clk_counter),
        .clk_ref_counter(clk_ref_counter), .clk_init(clk_init), .clk_status(clk_status)
    );

    always @(negedge ref_clk) begin
        if (!reset) begin
            if (busy && !clk_resetn) n_load++;
            if (busy && clk_resetn)  n_wait++;
            if (clk_resetn && !prev_rn) n_rise++;
            if (ack[0])  n_ack0++;
            if (ack[1])  n_ack1++;
            if (fail[0]) n_fail0++;
            if (fail[1]) n_fail1++;
            if ((ack & fail) != 2'b00) n_both++;
        end
        prev_rn = clk_resetn;
    end

    // Requesters drop req as soon as they see their result pulse.
    task automatic step;
        @(negedge ref_clk);
        req = req & ~(ack | fail);
    endtask

    task automatic run_until(input int limit, output bit hit);
        hit = 1'b0;
        seen_ack = 2'b00; seen_fail = 2'b00; seen_owner = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge ref_clk);
            if ((ack | fail) != 2'b00) begin
                hit = 1'b1;
                seen_ack = ack; seen_fail = fail; seen_owner = owner;
            end
            req = req & ~(ack | fail);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 2'b00; force_loss = 1'b0;
        step; step;
        checks++;
        if ({clk_resetn, ack, fail, owner, busy, locked} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {clk_resetn, ack, fail, owner, busy, locked});
        end
        checks++;
        if ({clk_counter, clk_ref_counter, clk_init, relock_cnt} !== 81'b0) begin
            errors++;
            $display("FAIL reset_cfg: got %0d/%0d/%0d/%0d expected all 0", clk_counter, clk_ref_counter, clk_init, relock_cnt);
        end
        reset = 1'b0;
        step;
    endtask

    task automatic test_basic_lock;
        int b_load, b_wait, b_ack;
        bit hit;
        b_load = n_load; b_wait = n_wait; b_ack = n_ack0;
        lock_mode = 1; req = 2'b01;
        run_until(200, hit);
        checks++;
        if (!hit || seen_ack !== 2'b01) begin
            errors++; $display("FAIL basic_ack: got %b expected 01", seen_ack);
        end
        step;
        checks++;
        if (n_load - b_load != 16) begin
            errors++; $display("FAIL basic_load_len: got %0d expected 16", n_load - b_load);
        end
        checks++;
        if (n_wait - b_wait != 8) begin
            errors++; $display("FAIL basic_wait_len: got %0d expected 8", n_wait - b_wait);
        end
        checks++;
        if (n_ack0 - b_ack != 1 || ack !== 2'b00) begin
            errors++; $display("FAIL basic_ack_pulse: got %0d pulses, ack=%b expected 1, 00", n_ack0 - b_ack, ack);
        end
        checks++;
        if ({locked, busy, owner, clk_resetn} !== 4'b1001) begin
            errors++; $display("FAIL basic_state: got %b expected 1001", {locked, busy, owner, clk_resetn});
        end
        checks++;
        if (clk_counter !== 32'd2000 || clk_ref_counter !== 32'd10 || clk_init !== 9'd20) begin
            errors++; $display("FAIL basic_cfg: got %0d/%0d/%0d expected 2000/10/20", clk_counter, clk_ref_counter, clk_init);
        end
    endtask

    task automatic test_arbitration;
        bit hit;
        lock_mode = 1; req = 2'b11;
        run_until(200, hit);
        checks++;
        if (!hit || seen_ack !== 2'b01 || seen_owner !== 1'b0) begin
            errors++; $display("FAIL arb_first: got ack=%b owner=%0d expected 01, 0", seen_ack, seen_owner);
        end
        run_until(200, hit);
        checks++;
        if (!hit || seen_ack !== 2'b10 || seen_owner !== 1'b1) begin
            errors++; $display("FAIL arb_second: got ack=%b owner=%0d expected 10, 1", seen_ack, seen_owner);
        end
        step;
        checks++;
        if (clk_counter !== 32'd4000 || clk_ref_counter !== 32'd20 || clk_init !== 9'd40 || locked !== 1'b1) begin
            errors++; $display("FAIL arb_cfg: got %0d/%0d/%0d locked=%0d expected 4000/20/40 1", clk_counter, clk_ref_counter, clk_init, locked);
        end
        checks++;
        if (req !== 2'b00) begin
            errors++; $display("FAIL arb_req_drop: got %b expected 00", req);
        end
    endtask

    task automatic test_loss_of_lock;
        int b_load, b_ack;
        bit done;
        force_loss = 1'b1;
        repeat (3) step;
        force_loss = 1'b0;
        step;
        checks++;
        if (locked !== 1'b1 || busy !== 1'b0 || relock_cnt !== 8'd0) begin
            errors++; $display("FAIL loss3_hold: got locked=%0d busy=%0d relock=%0d expected 1 0 0", locked, busy, relock_cnt);
        end
        b_load = n_load; b_ack = n_ack0 + n_ack1;
        force_loss = 1'b1;
        repeat (4) step;
        force_loss = 1'b0;
        checks++;
        if (relock_cnt !== 8'd1 || busy !== 1'b1 || locked !== 1'b0 || clk_resetn !== 1'b0) begin
            errors++; $display("FAIL loss4_relock: got relock=%0d busy=%0d locked=%0d rn=%0d expected 1 1 0 0", relock_cnt, busy, locked, clk_resetn);
        end
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step;
            done = locked;
        end
        step;
        checks++;
        if (!done || n_ack0 + n_ack1 - b_ack != 0) begin
            errors++; $display("FAIL relock_done: got locked=%0d acks=%0d expected 1, 0", done, n_ack0 + n_ack1 - b_ack);
        end
        checks++;
        if (n_load - b_load != 16 || clk_counter !== 32'd4000 || owner !== 1'b1) begin
            errors++; $display("FAIL relock_cfg: got load=%0d cnt=%0d owner=%0d expected 16 4000 1", n_load - b_load, clk_counter, owner);
        end
    endtask

    task automatic test_reset_mid_wait;
        int b_pulse;
        bit in_wait;
        lock_mode = 0; req = 2'b01;
        in_wait = 1'b0;
        for (int i = 0; i < 100 && !in_wait; i++) begin
            step;
            in_wait = busy && clk_resetn;
        end
        repeat (5) step;
        b_pulse = n_ack0 + n_ack1 + n_fail0 + n_fail1;
        reset = 1'b1;
        step;
        checks++;
        if (!in_wait || {clk_resetn, ack, fail, owner, busy, locked} !== 8'b0) begin
            errors++; $display("FAIL midwait_ctrl: got %b in_wait=%0d expected 00000000", {clk_resetn, ack, fail, owner, busy, locked}, in_wait);
        end
        checks++;
        if ({clk_counter, clk_ref_counter, clk_init, relock_cnt} !== 81'b0) begin
            errors++; $display("FAIL midwait_cfg: got %0d/%0d/%0d/%0d expected all 0", clk_counter, clk_ref_counter, clk_init, relock_cnt);
        end
        reset = 1'b0; req = 2'b00;
        repeat (20) step;
        checks++;
        if (n_ack0 + n_ack1 + n_fail0 + n_fail1 != b_pulse || busy !== 1'b0) begin
            errors++; $display("FAIL midwait_nopulse: got %0d pulses busy=%0d expected 0 0", n_ack0 + n_ack1 + n_fail0 + n_fail1 - b_pulse, busy);
        end
    endtask

    task automatic test_timeout_retry;
        int b_load, b_wait, b_rise, b_fail, b_ack;
        bit hit;
        b_load = n_load; b_wait = n_wait; b_rise = n_rise; b_fail = n_fail0; b_ack = n_ack0 + n_ack1;
        lock_mode = 0; req = 2'b01;
        run_until(13000, hit);
        checks++;
        if (!hit || seen_fail !== 2'b01 || seen_ack !== 2'b00) begin
            errors++; $display("FAIL timeout_fail: got fail=%b ack=%b expected 01 00", seen_fail, seen_ack);
        end
        step;
        checks++;
        if (n_load - b_load != 48 || n_wait - b_wait != 12288 || n_rise - b_rise != 3) begin
            errors++; $display("FAIL timeout_attempts: got load=%0d wait=%0d rises=%0d expected 48 12288 3", n_load - b_load, n_wait - b_wait, n_rise - b_rise);
        end
        checks++;
        if (n_fail0 - b_fail != 1 || n_ack0 + n_ack1 != b_ack || fail !== 2'b00) begin
            errors++; $display("FAIL timeout_pulses: got fails=%0d acks=%0d expected 1 0", n_fail0 - b_fail, n_ack0 + n_ack1 - b_ack);
        end
        checks++;
        if ({clk_resetn, locked, busy} !== 3'b000 || clk_counter !== 32'd2000) begin
            errors++; $display("FAIL timeout_state: got rn/locked/busy=%b cnt=%0d expected 000 2000", {clk_resetn, locked, busy}, clk_counter);
        end
    endtask

    task automatic test_retry_success;
        int b_load, b_wait, b_ack, b_fail;
        bit hit;
        b_load = n_load; b_wait = n_wait; b_ack = n_ack0; b_fail = n_fail0 + n_fail1;
        rise_base = n_rise;
        lock_mode = 2; req = 2'b01;
        run_until(9000, hit);
        checks++;
        if (!hit || seen_ack !== 2'b01 || seen_fail !== 2'b00) begin
            errors++; $display("FAIL retry_ack: got ack=%b fail=%b expected 01 00", seen_ack, seen_fail);
        end
        step;
        checks++;
        if (n_load - b_load != 32 || n_wait - b_wait != 4104) begin
            errors++; $display("FAIL retry_len: got load=%0d wait=%0d expected 32 4104", n_load - b_load, n_wait - b_wait);
        end
        checks++;
        if (n_ack0 - b_ack != 1 || n_fail0 + n_fail1 != b_fail || locked !== 1'b1) begin
            errors++; $display("FAIL retry_pulses: got acks=%0d fails=%0d locked=%0d expected 1 0 1", n_ack0 - b_ack, n_fail0 + n_fail1 - b_fail, locked);
        end
    endtask

    initial begin
        test_reset;
        test_basic_lock;
        test_reset;
        test_arbitration;
        test_loss_of_lock;
        test_reset_mid_wait;
        test_timeout_retry;
        test_retry_success;
        checks++;
        if (n_both != 0) begin
            errors++; $display("FAIL ack_fail_overlap: got %0d expected 0", n_both);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
